// File: rtl/amber_wb_inst_sequencer_pkg.sv
// Shared types and constants for the Amber23 Wishbone instruction sequencer.
package amber_wb_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        IDLE = 2'd1,
        ACK  = 2'd2
    } seq_state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'hE1A0_0000;
    localparam int          CNT_W       = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/amber_wb_inst_sequencer_if.sv
// Load-queue and core Wishbone signals of the sequencer, grouped as one bundle.
interface amber_wb_inst_sequencer_if;
    logic        i_ld_valid;
    logic        o_ld_ready;
    logic [31:0] i_ld_word;
    logic        i_flush;
    logic [31:0] i_wb_adr;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic [31:0] i_wb_dat;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic        o_system_rdy;
    logic        o_cap_valid;
    logic [31:0] o_cap_adr;
    logic [31:0] o_cap_dat;
    logic [3:0]  o_cap_sel;
    logic [15:0] o_rd_cnt;
    logic [15:0] o_underrun_cnt;

    modport slave (
        input  i_ld_valid, i_ld_word, i_flush,
        input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        output o_ld_ready, o_wb_dat, o_wb_ack, o_wb_err, o_system_rdy,
        output o_cap_valid, o_cap_adr, o_cap_dat, o_cap_sel,
        output o_rd_cnt, o_underrun_cnt
    );

    modport master (
        output i_ld_valid, i_ld_word, i_flush,
        output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        input  o_ld_ready, o_wb_dat, o_wb_ack, o_wb_err, o_system_rdy,
        input  o_cap_valid, o_cap_adr, o_cap_dat, o_cap_sel,
        input  o_rd_cnt, o_underrun_cnt
    );
endinterface

// File: rtl/amber_wb_inst_sequencer_fifo.sv
// Synchronous word FIFO holding the instruction/data stream fed to the core.
module amber_wb_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      occ_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full/empty come straight from the registered occupancy, so a pop never frees a slot for the same-cycle push.
    assign full      = (occ_r == (AW+1)'(DEPTH));
    assign empty     = (occ_r == (AW+1)'(0));
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage, pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            occ_r    <= (AW+1)'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            occ_r    <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   occ_r <= occ_r + (AW+1)'(1);
                2'b01:   occ_r <= occ_r - (AW+1)'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end
endmodule

// File: rtl/amber_wb_inst_sequencer.sv
// Wishbone slave that holds the Amber23 core in reset, feeds its reads from a load queue and captures its writes.
module amber_wb_inst_sequencer
    import amber_wb_seq_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          RDY_DELAY = 10,
    parameter logic [31:0] NOP_WORD  = NOP_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    amber_wb_inst_sequencer_if.slave  bus
);
    localparam logic [7:0] RDY_CMP = 8'(RDY_DELAY);

    seq_state_t       state_r;
    logic [7:0]       hold_cnt_r;
    logic             rdy_r;
    logic             ack_r;
    logic [31:0]      rd_dat_r;
    logic             cap_valid_r;
    logic [31:0]      cap_adr_r;
    logic [31:0]      cap_dat_r;
    logic [3:0]       cap_sel_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [CNT_W-1:0] underrun_cnt_r;

    logic             accept_s;
    logic             rd_req_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [31:0]      head_s;

    // Request qualification; a flush in the same cycle turns a read into an underrun and suppresses the pop.
    always_comb begin
        accept_s = 1'b0;
        rd_req_s = 1'b0;
        pop_s    = 1'b0;
        if (state_r == IDLE) begin
            accept_s = bus.i_wb_cyc & bus.i_wb_stb;
            rd_req_s = accept_s & ~bus.i_wb_we;
            pop_s    = rd_req_s & ~empty_s & ~bus.i_flush;
        end else begin
            accept_s = 1'b0;
        end
    end

    amber_wb_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (bus.i_ld_valid),
        .pop     (pop_s),
        .flush   (bus.i_flush),
        .wr_data (bus.i_ld_word),
        .head    (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Sequencer FSM with all bus-facing outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r        <= HOLD;
            hold_cnt_r     <= 8'd0;
            rdy_r          <= 1'b0;
            ack_r          <= 1'b0;
            rd_dat_r       <= 32'd0;
            cap_valid_r    <= 1'b0;
            cap_adr_r      <= 32'd0;
            cap_dat_r      <= 32'd0;
            cap_sel_r      <= 4'd0;
            rd_cnt_r       <= {CNT_W{1'b0}};
            underrun_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                HOLD: begin
                    ack_r       <= 1'b0;
                    cap_valid_r <= 1'b0;
                    if (hold_cnt_r == RDY_CMP) begin
                        state_r <= IDLE;
                        rdy_r   <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                    end
                end
                IDLE: begin
                    if (accept_s) begin
                        state_r <= ACK;
                        ack_r   <= 1'b1;
                        if (bus.i_wb_we) begin
                            cap_valid_r <= 1'b1;
                            cap_adr_r   <= bus.i_wb_adr;
                            cap_dat_r   <= bus.i_wb_dat;
                            cap_sel_r   <= bus.i_wb_sel;
                        end else begin
                            cap_valid_r <= 1'b0;
                            rd_cnt_r    <= sat_inc(rd_cnt_r);
                            if (empty_s || bus.i_flush) begin
                                rd_dat_r       <= NOP_WORD;
                                underrun_cnt_r <= sat_inc(underrun_cnt_r);
                            end else begin
                                rd_dat_r <= head_s;
                            end
                        end
                    end else begin
                        ack_r       <= 1'b0;
                        cap_valid_r <= 1'b0;
                    end
                end
                ACK: begin
                    state_r     <= IDLE;
                    ack_r       <= 1'b0;
                    cap_valid_r <= 1'b0;
                end
                default: begin
                    state_r     <= HOLD;
                    ack_r       <= 1'b0;
                    cap_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ld_ready     = ~full_s;
    assign bus.o_wb_dat       = rd_dat_r;
    assign bus.o_wb_ack       = ack_r;
    assign bus.o_wb_err       = 1'b0;
    assign bus.o_system_rdy   = rdy_r;
    assign bus.o_cap_valid    = cap_valid_r;
    assign bus.o_cap_adr      = cap_adr_r;
    assign bus.o_cap_dat      = cap_dat_r;
    assign bus.o_cap_sel      = cap_sel_r;
    assign bus.o_rd_cnt       = rd_cnt_r;
    assign bus.o_underrun_cnt = underrun_cnt_r;
endmodule
